sme_dom_alu: RTL and testbench

- Pipelined, parametrised masked bitwise unit for the SME datapath.
- Operates on D-share Boolean-masked operands of width N.
- Supports AND, ANDN, OR, XOR and REFRESH using domain-oriented masking (DOM), with all cross-domain terms registered before compression.
- Elastic valid/ready input, randomness and output interfaces; sits between the SME operand read stage and share writeback.

---
 rtl/sme_pkg.sv | 29 ++
 rtl/sme_dom_alu_if.sv | 32 +++
 rtl/sme_dom_term_reg.sv | 21 ++
 rtl/sme_dom_alu.sv | 121 ++++++++++++
 tb/tb_sme_dom_alu.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared SME datapath types and helpers for the DOM masked ALU
package sme_pkg;

    typedef enum logic [2:0] {
        DOM_AND     = 3'd0,
        DOM_ANDN    = 3'd1,
        DOM_OR      = 3'd2,
        DOM_XOR     = 3'd3,
        DOM_REFRESH = 3'd4
    } sme_dom_op_t;

    function automatic int sme_rng_width(input int d, input int n);
        return n * d * (d - 1) / 2;
    endfunction

    // Order-independent: pair (i,j) and (j,i) share one random word.
    function automatic int sme_pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo + hi * (hi - 1) / 2;
    endfunction

    function automatic logic sme_needs_rng(input logic [2:0] op);
        return (op == DOM_AND) || (op == DOM_ANDN) || (op == DOM_OR) || (op == DOM_REFRESH);
    endfunction

endpackage

// File: rtl/sme_dom_alu_if.sv
// rtl/sme_dom_alu_if.sv - operand, randomness and result handshakes of the DOM ALU
interface sme_dom_alu_if #(
    parameter int D = 3,
    parameter int N = 32
);
    import sme_pkg::*;

    localparam int RW = sme_rng_width(D, N);

    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [D-1:0][N-1:0]   rs1;
    logic [D-1:0][N-1:0]   rs2;
    logic                  rng_valid;
    logic                  rng_ready;
    logic [RW-1:0]         rng;
    logic                  out_valid;
    logic                  out_ready;
    logic [D-1:0][N-1:0]   rd;

    modport master (
        output in_valid, in_op, rs1, rs2, rng_valid, rng, out_ready,
        input  in_ready, rng_ready, out_valid, rd
    );

    modport slave (
        input  in_valid, in_op, rs1, rs2, rng_valid, rng, out_ready,
        output in_ready, rng_ready, out_valid, rd
    );

endinterface

// File: rtl/sme_dom_term_reg.sv
// rtl/sme_dom_term_reg.sv - one domain's D registered DOM terms
module sme_dom_term_reg #(
    parameter int D = 3,
    parameter int N = 32
) (
    input  logic                g_clk,
    input  logic                g_reset,
    input  logic                en,
    input  logic [D-1:0][N-1:0] d_terms,
    output logic [D-1:0][N-1:0] q_terms
);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            q_terms <= '0;
        end else if (en) begin
            q_terms <= d_terms;
        end
    end

endmodule

// File: rtl/sme_dom_alu.sv
// rtl/sme_dom_alu.sv - two-stage DOM masked AND/ANDN/OR/XOR/REFRESH unit
module sme_dom_alu
    import sme_pkg::*;
#(
    parameter int D = 3,
    parameter int N = 32
) (
    input  logic         g_clk,
    input  logic         g_reset,
    sme_dom_alu_if.slave bus
);

    logic                          needs_rng;
    logic                          fire;
    logic                          s1_valid;
    logic                          s1_inv;
    logic                          s1_advance;
    logic                          s2_valid;
    logic [D-1:0][N-1:0]           x;
    logic [D-1:0][N-1:0]           y;
    logic [D-1:0][D-1:0][N-1:0]    t_d;
    logic [D-1:0][D-1:0][N-1:0]    t_q;
    logic [D-1:0][N-1:0]           rd_d;
    logic [D-1:0][N-1:0]           rd_q;

    assign needs_rng     = sme_needs_rng(bus.in_op);
    assign s1_advance    = ~s2_valid | (s2_valid & bus.out_ready);
    assign bus.in_ready  = ~g_reset & (~s1_valid | s1_advance);
    assign fire          = bus.in_valid & bus.in_ready & (bus.rng_valid | ~needs_rng);
    assign bus.rng_ready = fire & needs_rng;

    // Every op is expressed as a D x D term matrix so stage 2 is a uniform
    // per-domain XOR; XOR and REFRESH simply park their values in the slots.
    always_comb begin
        x   = bus.rs1;
        y   = bus.rs2;
        t_d = '0;
        if (bus.in_op == DOM_ANDN) begin
            y[0] = ~bus.rs2[0];
        end else if (bus.in_op == DOM_OR) begin
            x[0] = ~bus.rs1[0];
            y[0] = ~bus.rs2[0];
        end
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                case (bus.in_op)
                    DOM_AND, DOM_ANDN, DOM_OR: begin
                        t_d[i][j] = x[i] & y[j];
                        if (i != j) begin
                            t_d[i][j] = t_d[i][j] ^ bus.rng[sme_pair_idx(i, j)*N +: N];
                        end
                    end
                    DOM_XOR: begin
                        if (i == j) begin
                            t_d[i][j] = x[i] ^ y[i];
                        end
                    end
                    DOM_REFRESH: begin
                        if (i == j) begin
                            t_d[i][j] = x[i];
                        end else begin
                            t_d[i][j] = bus.rng[sme_pair_idx(i, j)*N +: N];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < D; g++) begin : g_dom
        sme_dom_term_reg #(
            .D (D),
            .N (N)
        ) u_term (
            .g_clk   (g_clk),
            .g_reset (g_reset),
            .en      (fire),
            .d_terms (t_d[g]),
            .q_terms (t_q[g])
        );
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            s1_valid <= 1'b0;
            s1_inv   <= 1'b0;
        end else if (fire) begin
            s1_valid <= 1'b1;
            s1_inv   <= (bus.in_op == DOM_OR);
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                rd_d[i] = rd_d[i] ^ t_q[i][j];
            end
        end
        rd_d[0] = rd_d[0] ^ {N{s1_inv}};
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            s2_valid <= 1'b0;
            rd_q     <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                rd_q <= rd_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.rd        = rd_q;

endmodule

// File: tb/tb_sme_dom_alu.sv
// tb/tb_sme_dom_alu.sv - scoreboard bench for sme_dom_alu at D=2/N=8 and D=3/N=32
module tb_sme_dom_alu;
    import sme_pkg::*;

    logic g_clk = 1'b0;
    logic g_reset;
    always #5 g_clk = ~g_clk;

    sme_dom_alu_if #(.D(2), .N(8))  a2 ();
    sme_dom_alu_if #(.D(3), .N(32)) a3 ();

    sme_dom_alu #(.D(2), .N(8)) u_dut2 (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (a2.slave)
    );

    sme_dom_alu #(.D(3), .N(32)) u_dut3 (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (a3.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] golden(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int n);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a & ~b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = a;
            default: r = '0;
        endcase
        return r & mask;
    endfunction

    function automatic logic fire2_now();
        return a2.in_valid & a2.in_ready & (a2.rng_valid | ~sme_needs_rng(a2.in_op));
    endfunction

    function automatic logic fire3_now();
        return a3.in_valid & a3.in_ready & (a3.rng_valid | ~sme_needs_rng(a3.in_op));
    endfunction

    logic [63:0] q2[$];
    logic [63:0] q3[$];
    logic        fire3;

    // D=2 monitor: rng handshake, scoreboard, hold-under-stall
    initial begin
        logic        f;
        logic        stall_prev;
        logic [15:0] held;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge g_clk);
            if (g_reset) begin
                q2.delete();
                stall_prev = 1'b0;
            end else begin
                f = fire2_now();
                check("rng_ready2", a2.rng_ready, f & sme_needs_rng(a2.in_op));
                if (f) begin
                    q2.push_back(golden(a2.in_op, a2.rs1[0] ^ a2.rs1[1], a2.rs2[0] ^ a2.rs2[1], 8));
                end
                if (stall_prev) check("hold2", a2.rd, held);
                if (a2.out_valid && a2.out_ready) begin
                    if (q2.size() == 0) check("extra_out2", 1, 0);
                    else check("rd2", a2.rd[0] ^ a2.rd[1], q2.pop_front());
                end
                stall_prev = a2.out_valid & ~a2.out_ready;
                held       = a2.rd;
            end
        end
    end

    // D=3 monitor
    initial begin
        fire3 = 1'b0;
        forever begin
            @(negedge g_clk);
            if (g_reset) begin
                q3.delete();
                fire3 = 1'b0;
            end else begin
                fire3 = fire3_now();
                check("rng_ready3", a3.rng_ready, fire3 & sme_needs_rng(a3.in_op));
                if (fire3) begin
                    q3.push_back(golden(a3.in_op, a3.rs1[0] ^ a3.rs1[1] ^ a3.rs1[2],
                                        a3.rs2[0] ^ a3.rs2[1] ^ a3.rs2[2], 32));
                end
                if (a3.out_valid && a3.out_ready) begin
                    if (q3.size() == 0) check("extra_out3", 1, 0);
                    else check("rd3", a3.rd[0] ^ a3.rd[1] ^ a3.rd[2], q3.pop_front());
                end
            end
        end
    end

    task automatic do_op2(input logic [2:0] op, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] r,
                          input int rng_hold, output logic [7:0] o0, output logic [7:0] o1);
        int   stalls;
        int   n;
        int   rr;
        logic fired;
        logic got;
        stalls = 0; n = 0; rr = 0; fired = 0; got = 0;
        o0 = '0; o1 = '0;
        @(posedge g_clk); #1;
        a2.in_valid  = 1'b1;
        a2.in_op     = op;
        a2.rs1[0]    = a0; a2.rs1[1] = a1;
        a2.rs2[0]    = b0; a2.rs2[1] = b1;
        a2.rng       = r;
        a2.rng_valid = (rng_hold == 0);
        for (int c = 0; c < 50 && !fired; c++) begin
            @(negedge g_clk);
            if (a2.rng_ready) rr++;
            if (fire2_now()) begin
                fired = 1'b1;
            end else begin
                stalls++;
                @(posedge g_clk); #1;
                if (c + 1 == rng_hold) a2.rng_valid = 1'b1;
            end
        end
        @(posedge g_clk); #1;
        a2.in_valid  = 1'b0;
        a2.rng_valid = 1'b0;
        if (!fired) begin
            check("fire_timeout", 0, 1);
            return;
        end
        check("rng_stall_cycles", stalls, (rng_hold < 0) ? 0 : rng_hold);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge g_clk);
            n++;
            if (a2.rng_ready) rr++;
            if (a2.out_valid) begin
                got = 1'b1;
                o0  = a2.rd[0];
                o1  = a2.rd[1];
            end
        end
        if (!got) check("out_timeout", 0, 1);
        else check("latency", n, 2);
        check("rng_ready_pulses", rr, sme_needs_rng(op) ? 1 : 0);
    endtask

    task automatic stream2();
        logic f;
        @(posedge g_clk); #1;
        for (int k = 0; k < 8; k++) begin
            a2.in_valid  = 1'b1;
            a2.in_op     = 3'd0;
            a2.rs1       = 16'($urandom());
            a2.rs2       = 16'($urandom());
            a2.rng       = 8'($urandom());
            a2.rng_valid = 1'b1;
            f = 1'b0;
            for (int c = 0; c < 50 && !f; c++) begin
                @(negedge g_clk);
                f = fire2_now();
                if (!f) begin
                    @(posedge g_clk); #1;
                end
            end
            if (!f) check("stream_timeout", 0, 1);
            @(posedge g_clk); #1;
        end
        a2.in_valid  = 1'b0;
        a2.rng_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        int sz;
        for (int c = 0; c < 40; c++) @(negedge g_clk);
        sz = (which == 2) ? q2.size() : q3.size();
        check((which == 2) ? "drain2" : "drain3", sz, 0);
    endtask

    initial begin
        logic [7:0] o0;
        logic [7:0] o1;
        g_reset = 1'b1;
        a2.in_valid = 0; a2.in_op = 0; a2.rs1 = '0; a2.rs2 = '0;
        a2.rng_valid = 0; a2.rng = '0; a2.out_ready = 1;
        a3.in_valid = 0; a3.in_op = 0; a3.rs1 = '0; a3.rs2 = '0;
        a3.rng_valid = 0; a3.rng = '0; a3.out_ready = 1;
        repeat (3) @(posedge g_clk);
        #1 g_reset = 1'b0;
        @(negedge g_clk);
        check("rst_out_valid", a2.out_valid, 0);
        check("rst_rd", a2.rd, 0);
        check("rst_in_ready", a2.in_ready, 1);

        do_op2(3'd0, 8'hF0, 8'h3C, 8'h0F, 8'hA5, 8'h5E, 0, o0, o1);
        check("and_unmasked", o0 ^ o1, 8'h88);
        do_op2(3'd1, 8'hF0, 8'h3C, 8'h0F, 8'hA5, 8'h5E, 0, o0, o1);
        check("andn_unmasked", o0 ^ o1, 8'h44);
        do_op2(3'd2, 8'hF0, 8'h3C, 8'h0F, 8'hA5, 8'h5E, 0, o0, o1);
        check("or_unmasked", o0 ^ o1, 8'hEE);
        do_op2(3'd3, 8'hF0, 8'h3C, 8'h0F, 8'hA5, 8'h5E, -1, o0, o1);
        check("xor_unmasked", o0 ^ o1, 8'h66);
        do_op2(3'd4, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'hFF, 0, o0, o1);
        check("refresh_rd0", o0, 8'h0F);
        check("refresh_rd1", o1, 8'hC3);
        do_op2(3'd6, 8'hF0, 8'h3C, 8'h0F, 8'hA5, 8'h5E, -1, o0, o1);
        check("reserved_rd", {o0, o1}, 16'h0000);
        do_op2(3'd0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 4, o0, o1);
        check("rng_wait_unmasked", o0 ^ o1, 8'h26 & 8'h2E);

        fork
            stream2();
            begin
                repeat (4) @(posedge g_clk);
                #1 a2.out_ready = 1'b0;
                repeat (3) @(negedge g_clk);
                check("in_ready_full", a2.in_ready, 0);
                @(posedge g_clk); #1 a2.out_ready = 1'b1;
            end
        join
        drain(2);

        // fill both stages, then reset with them full
        @(posedge g_clk); #1;
        a2.out_ready = 1'b0;
        a2.in_valid = 1'b1; a2.in_op = 3'd3; a2.rng_valid = 1'b0;
        a2.rs1 = 16'hABCD; a2.rs2 = 16'h1234;
        repeat (2) @(posedge g_clk);
        #1 a2.in_valid = 1'b0;
        @(negedge g_clk);
        check("full_out_valid", a2.out_valid, 1);
        check("full_in_ready", a2.in_ready, 0);
        @(posedge g_clk); #1 g_reset = 1'b1;
        @(posedge g_clk); #1 g_reset = 1'b0;
        @(negedge g_clk);
        check("midrst_out_valid", a2.out_valid, 0);
        check("midrst_rd", a2.rd, 0);
        a2.out_ready = 1'b1;
        do_op2(3'd0, 8'hF0, 8'h3C, 8'h0F, 8'hA5, 8'h5E, 0, o0, o1);
        check("post_rst_and", o0 ^ o1, 8'h88);
        drain(2);

        // randomised traffic on the D=3 instance
        for (int c = 0; c < 4000; c++) begin
            @(posedge g_clk); #1;
            if (!a3.in_valid || fire3) begin
                a3.in_valid = ($urandom_range(0, 3) != 0);
                a3.in_op    = 3'($urandom_range(0, 7));
                for (int s = 0; s < 3; s++) begin
                    a3.rs1[s] = $urandom();
                    a3.rs2[s] = $urandom();
                end
            end
            for (int s = 0; s < 3; s++) a3.rng[s*32 +: 32] = $urandom();
            a3.rng_valid = ($urandom_range(0, 3) != 0);
            a3.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge g_clk); #1;
        a3.in_valid  = 1'b0;
        a3.rng_valid = 1'b0;
        a3.out_ready = 1'b1;
        drain(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
